seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, successor to the team's fixed 4-bit "1011" detector. It samples one serial bit per qualified clock and compares the most recent bits against a runtime-programmable pattern of 1..PAT_W bits. Overlapping or non-overlapping match mode is selectable, and a saturating match counter is kept. It sits on the bit-serial side of the line-decode path and feeds frame-sync and statistics logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (2..32).
- CNT_W, 16: match counter width.
- DEF_PAT, 8'b0000_1011: pattern loaded at reset, LSB-aligned.
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVL, 1: overlap mode at reset (1 = overlapping).
- LEN_W, derived, $clog2(PAT_W+1): width of length fields.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- data  in  1  serial input bit.
- data_valid  in  1  qualifies data on this edge.
- cfg_load  in  1  strobe; latch cfg_* and flush history.
- cfg_pattern  in  PAT_W  pattern. Bit len-1 is the first bit on the wire; bit 0 is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  overlap mode select.
- cnt_clr  in  1  synchronous clear of match_cnt.
- flag  out  1  one-cycle match pulse, registered.
- match_cnt  out  CNT_W  saturating match count.
- cfg_err  out  1  high while the active length is illegal (0 or >PAT_W).

## Operation
- Active config registers: pat_q, len_q, ovl_q. Reset loads DEF_*. cfg_load overwrites them.
- History shift register shreg[PAT_W-1:0]. On data_valid: shreg <= {shreg[PAT_W-2:0], data}, so the newest bit is at LSB.
- fill_q counts valid bits in history and saturates at PAT_W.
- upd_q <= data_valid. It marks that history changed at the last edge, which prevents re-reporting a stale match.
- hit is combinational: upd_q && !cfg_err && fill_q >= len_q && shreg[len_q-1:0] == pat_q[len_q-1:0]. The comparison is masked to len_q bits.
- flag <= hit.
- match_cnt <= match_cnt+1 on hit, saturating at all-ones.
- Overlap mode: fill_q keeps counting on hit, so shared suffix/prefix bits may start the next match.
- Non-overlap mode: on a hit edge, fill_q <= data_valid ? 1 : 0. The bit arriving on that same edge begins the new history.
- cfg_load:
  - latches config;
  - clears shreg, fill_q and upd_q;
  - ignores data_valid on that edge;
  - leaves match_cnt unchanged;
  - forces flag 0 on the next cycle.
- cfg_err = (len_q == 0) || (len_q > PAT_W). While cfg_err is high there are no hits, but history still shifts.
- Priority in the same cycle: rst > cfg_load > hit/shift. For match_cnt: cnt_clr > increment.
- Reset values: flag 0, match_cnt 0, shreg 0, fill_q 0, upd_q 0, config = DEF_*. cfg_err follows DEF_LEN.

## Timing
- Last pattern bit sampled at edge t, then flag high for exactly the cycle after edge t+1. This is the same two-edge latency as the legacy detector.
- match_cnt updates on the same edge as flag rises.
- Back-to-back valid bits give at most one flag per valid bit. Idle cycles (data_valid=0) never produce a flag.
- Gaps in data_valid do not break a match; history is bit-indexed, not cycle-indexed.
- rst asserted mid-match: on the next edge all state returns to reset values, and any pending hit is dropped.
- cfg_load in the same cycle as hit: the hit is discarded (no flag, no count).
- cnt_clr in the same cycle as hit: match_cnt = 0 and flag still pulses.

## Structure
- Package seq_detect_pkg contains:
  - the LEN_W computation function;
  - the default pattern, length and overlap constants;
  - a typedef for the config bundle (pattern, len, overlap).
- One sub-module, seq_match_cmp. It is a combinational masked compare of shreg against pat_q over len_q bits and returns eq. The top instantiates it once and holds all sequential logic.

## Test plan
- Defaults (1011, overlap), data stream 1,0,1,1,0,1,1: flag pulses twice, 2 cycles after the 4th and 7th bits; match_cnt = 2.
- cfg_load pattern 3'b111, len 3, overlap=0, stream of five 1s: one flag, after bit 3; match_cnt +1. With overlap=1 the same stream gives three flags.
- PAT_W=8, len 8, pattern 8'hA5, stream A5 A5 with data_valid toggled off every other cycle: two flags, each two edges after the final bit; none during idle cycles.
- cfg_len=0, then len=9 with PAT_W=8: cfg_err=1 and no flag for any stream. Reloading len 4 clears cfg_err on the next cycle.
- CNT_W=2, five matches of 1011: match_cnt reads 1,2,3,3,3. cnt_clr together with a hit gives match_cnt=0 and flag=1.
- rst pulsed after bits 1,0,1 of 1011, then bit 1: no flag. cfg_load issued on the hit cycle: no flag, no count.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants, length-width helper and config bundle type for the
// parametrised serial pattern detector.
package seq_detect_pkg;

    localparam int SEQ_MAX_PAT_W = 32;

    localparam logic [SEQ_MAX_PAT_W-1:0] SEQ_DEF_PAT = 32'h0000_000B;
    localparam int                       SEQ_DEF_LEN = 4;
    localparam bit                       SEQ_DEF_OVL = 1'b1;

    // Width needed to hold a length in 0..pat_w inclusive.
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    typedef struct packed {
        logic [SEQ_MAX_PAT_W-1:0] pattern;
        logic [5:0]               len;
        logic                     overlap;
    } seq_cfg_t;

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational compare of the history register against the pattern,
// restricted to the low len bits.
module seq_match_cmp #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             eq
);

    logic [PAT_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign eq = ~|((hist ^ pat) & mask);

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-programmable pattern/length,
// overlap mode select and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT),
    parameter int               DEF_LEN = SEQ_DEF_LEN,
    parameter bit               DEF_OVL = SEQ_DEF_OVL,
    localparam int              LEN_W   = calc_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             data_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [PAT_W-1:0] shreg;
    logic [LEN_W-1:0] fill_q;
    logic             upd_q;
    logic             eq;
    logic             hit;

    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist (shreg),
        .pat  (pat_q),
        .len  (len_q),
        .eq   (eq)
    );

    assign cfg_err = (len_q == '0) || (len_q > LEN_W'(PAT_W));

    // upd_q gates the compare so a match is reported once per new bit.
    assign hit = upd_q && !cfg_err && (fill_q >= len_q) && eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVL;
            shreg  <= '0;
            fill_q <= '0;
            upd_q  <= 1'b0;
            flag   <= 1'b0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= cfg_len;
            ovl_q  <= cfg_overlap;
            shreg  <= '0;
            fill_q <= '0;
            upd_q  <= 1'b0;
            flag   <= 1'b0;
        end else begin
            flag  <= hit;
            upd_q <= data_valid;
            if (data_valid) begin
                shreg <= {shreg[PAT_W-2:0], data};
            end
            // Non-overlap restarts history; the bit on this edge is its first.
            if (hit && !ovl_q) begin
                fill_q <= data_valid ? LEN_W'(1) : '0;
            end else if (data_valid && (fill_q != LEN_W'(PAT_W))) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (hit && !cfg_load && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: expected match per driven bit is
// queued and checked, with count model, when the flag appears.
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = 4;
    localparam int EXP_W = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             data;
    logic             data_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;

    seq_detect_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .data_valid  (data_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .flag        (flag),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               fails   = 0;
    logic [CNT_W-1:0] m_cnt   = '0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. e says whether the bit driven here completes a
    // match; it shows on flag one edge later unless that edge is rst/load.
    task automatic step(input logic dv, input logic d, input logic ld,
                        input logic clr, input logic rs, input logic e);
        logic [EXP_W-1:0] pend;
        logic             ef;
        data_valid = dv;
        data       = d;
        cfg_load   = ld;
        cnt_clr    = clr;
        rst        = rs;
        exp_q.push_back((rs || ld) ? 1'b0 : e);
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) begin
            pend = exp_q.pop_front();
            if (rs) begin
                ef    = 1'b0;
                m_cnt = '0;
            end else if (ld) begin
                ef = 1'b0;
                if (clr) m_cnt = '0;
            end else begin
                ef = pend[0];
                if (clr) m_cnt = '0;
                else if (pend[0] && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end
            chk("flag", {31'd0, flag}, {31'd0, ef});
            chk("match_cnt", {30'd0, match_cnt}, {30'd0, m_cnt});
        end
    endtask

    task automatic bit_in(input logic d, input logic e);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] a5;
        a5          = 8'hA5;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;

        // Reset and reset-state checks.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_flag", {31'd0, flag}, 32'd0);
        chk("rst_cnt", {30'd0, match_cnt}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);

        // Default 1011 overlapping: 1,0,1,1,0,1,1 gives two matches.
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 1);
        bit_in(0, 0); bit_in(1, 0); bit_in(1, 1);
        idle(); idle();
        chk("t1_cnt", {30'd0, match_cnt}, 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 111 non-overlap over five 1s: one match.
        load(8'b0000_0111, 4'd3, 1'b0);
        bit_in(1, 0); bit_in(1, 0); bit_in(1, 1); bit_in(1, 0); bit_in(1, 0);
        idle();
        // Same stream overlapping: three matches, counter saturates.
        load(8'b0000_0111, 4'd3, 1'b1);
        bit_in(1, 0); bit_in(1, 0); bit_in(1, 1); bit_in(1, 1); bit_in(1, 1);
        idle(); idle();
        chk("t2_sat", {30'd0, match_cnt}, 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // A5 A5, full width, idle cycle after every bit.
        load(8'hA5, 4'd8, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bit_in(a5[7 - (i % 8)], (i % 8) == 7);
            idle();
        end
        idle();

        // Illegal lengths: no matches, cfg_err high.
        load(8'b0000_1011, 4'd0, 1'b1);
        chk("len0_err", {31'd0, cfg_err}, 32'd1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); idle();
        load(8'b0000_1011, 4'd9, 1'b1);
        chk("len9_err", {31'd0, cfg_err}, 32'd1);
        for (int i = 0; i < 10; i++) bit_in(1'(i % 2), 0);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0); idle();
        load(8'b0000_1011, 4'd4, 1'b1);
        chk("len4_err", {31'd0, cfg_err}, 32'd0);

        // Five overlapping matches with random gaps: count 1,2,3,3,3.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bit_in(1, 0);
        for (int m = 0; m < 5; m++) begin
            bit_in(0, 0);
            repeat ($urandom_range(0, 2)) idle();
            bit_in(1, 0);
            bit_in(1, 1);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();
        chk("t5_sat", {30'd0, match_cnt}, 32'd3);

        // cnt_clr on the hit cycle: flag pulses, count goes to zero.
        load(8'b0000_1011, 4'd4, 1'b1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_hit_cnt", {30'd0, match_cnt}, 32'd0);

        // rst mid-pattern drops the partial history.
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bit_in(1, 0);
        idle(); idle();

        // cfg_load on the hit cycle discards the hit.
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 1);
        load(8'b0000_1011, 4'd4, 1'b1);
        idle(); idle();
        chk("load_hit_cnt", {30'd0, match_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
